// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus between the datapath and pipe_ctrl.
//   EX-stage redirect info : pc_ex, jmp_enable_ex, jmp_dir_ex,
//                            branch_enable_ex, branch_dir_ex, branch_cond
//   ID-stage read flags    : read_a_id, read_b_id
//   In-flight write selects: sel_{a,b}_{ex,me,wb} (2'b00 = no write)
//   Control outputs        : pc_sel, pc_target, pc_enable, ifid_enable,
//                            idex_flush, state, stall_count
// The slave modport is the controller; the master modport is the datapath.
interface pipe_ctrl_if;
  logic [9:0]  pc_ex;
  logic        jmp_enable_ex;
  logic [9:0]  jmp_dir_ex;
  logic        branch_enable_ex;
  logic [5:0]  branch_dir_ex;
  logic        branch_cond;
  logic        read_a_id;
  logic        read_b_id;
  logic [1:0]  sel_a_ex;
  logic [1:0]  sel_a_me;
  logic [1:0]  sel_a_wb;
  logic [1:0]  sel_b_ex;
  logic [1:0]  sel_b_me;
  logic [1:0]  sel_b_wb;
  logic        pc_sel;
  logic [9:0]  pc_target;
  logic        pc_enable;
  logic        ifid_enable;
  logic        idex_flush;
  logic [1:0]  state;
  logic [15:0] stall_count;

  modport master (
    output pc_ex, jmp_enable_ex, jmp_dir_ex, branch_enable_ex, branch_dir_ex,
           branch_cond, read_a_id, read_b_id, sel_a_ex, sel_a_me, sel_a_wb,
           sel_b_ex, sel_b_me, sel_b_wb,
    input  pc_sel, pc_target, pc_enable, ifid_enable, idex_flush, state,
           stall_count
  );

  modport slave (
    input  pc_ex, jmp_enable_ex, jmp_dir_ex, branch_enable_ex, branch_dir_ex,
           branch_cond, read_a_id, read_b_id, sel_a_ex, sel_a_me, sel_a_wb,
           sel_b_ex, sel_b_me, sel_b_wb,
    output pc_sel, pc_target, pc_enable, ifid_enable, idex_flush, state,
           stall_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: PC-redirect and hazard-stall controller for a 5-stage pipeline.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - pipe_ctrl_if.slave (EX redirect info, ID read flags, in-flight
//          write selects in; PC mux/enables, ID/EX flush, state and
//          saturating stall counter out)
// After reset BOOT_CYCLES bubbles are issued while the synchronous ROM fills
// IF; after a taken jump/branch FLUSH_CYCLES further bubbles follow the
// redirect cycle itself.
module pipe_ctrl #(
  parameter int BOOT_CYCLES  = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    STALL = 2'd3
  } state_t;

  localparam logic [15:0] BOOT_LOAD  = 16'(BOOT_CYCLES - 1);
  localparam logic [15:0] FLUSH_LOAD = 16'(FLUSH_CYCLES - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] stall_cnt;
  logic        stall_inc;

  logic        redirect;
  logic        hazard;
  logic [9:0]  target;

  logic signed [5:0] br_off;
  logic signed [9:0] br_off_ext;

  // Branch offset is sign-extended; the 10-bit add wraps modulo 1024.
  assign br_off     = bus.branch_dir_ex;
  assign br_off_ext = 10'(br_off);

  assign redirect = bus.jmp_enable_ex | (bus.branch_enable_ex & bus.branch_cond);
  assign target   = bus.jmp_enable_ex ? bus.jmp_dir_ex
                                      : bus.pc_ex + $unsigned(br_off_ext);

  // WB writes still hazard: the register file updates at the end of WB.
  assign hazard = (bus.read_a_id & ((bus.sel_a_ex != 2'b00) |
                                    (bus.sel_a_me != 2'b00) |
                                    (bus.sel_a_wb != 2'b00))) |
                  (bus.read_b_id & ((bus.sel_b_ex != 2'b00) |
                                    (bus.sel_b_me != 2'b00) |
                                    (bus.sel_b_wb != 2'b00)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      cnt       <= BOOT_LOAD;
      stall_cnt <= 16'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    stall_inc       = 1'b0;
    bus.pc_sel      = 1'b0;
    bus.pc_target   = 10'd0;
    bus.pc_enable   = 1'b1;
    bus.ifid_enable = 1'b1;
    bus.idex_flush  = 1'b0;
    case (state)
      BOOT, FLUSH: begin
        // Redirect and hazard inputs are deliberately ignored here.
        bus.idex_flush = 1'b1;
        if (cnt == 16'd0) state_n = RUN;
        else              cnt_n   = cnt - 16'd1;
      end
      RUN, STALL: begin
        if (redirect) begin
          // A stalled ID instruction is squashed by this flush.
          bus.pc_sel     = 1'b1;
          bus.pc_target  = target;
          bus.idex_flush = 1'b1;
          cnt_n          = FLUSH_LOAD;
          state_n        = FLUSH;
        end else if (hazard) begin
          bus.pc_enable   = 1'b0;
          bus.ifid_enable = 1'b0;
          bus.idex_flush  = 1'b1;
          stall_inc       = 1'b1;
          state_n         = STALL;
        end else begin
          state_n = RUN;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  assign bus.state       = state;
  assign bus.stall_count = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  logic [15:0] exp_stall = 16'd0;

  pipe_ctrl_if bus();

  pipe_ctrl #(.BOOT_CYCLES(2), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.pc_ex = 10'd0; bus.jmp_enable_ex = 1'b0; bus.jmp_dir_ex = 10'd0;
    bus.branch_enable_ex = 1'b0; bus.branch_dir_ex = 6'd0; bus.branch_cond = 1'b0;
    bus.read_a_id = 1'b0; bus.read_b_id = 1'b0;
    bus.sel_a_ex = 2'b00; bus.sel_a_me = 2'b00; bus.sel_a_wb = 2'b00;
    bus.sel_b_ex = 2'b00; bus.sel_b_me = 2'b00; bus.sel_b_wb = 2'b00;
  endtask

  // Clears inputs and walks through the two FLUSH cycles back into RUN.
  task automatic flush_out();
    clear_inputs();
    tick(); tick(); tick();
  endtask

  task automatic check_boot(input string tag);
    #1;
    nvec++; if (bus.state !== 2'd0 || bus.idex_flush !== 1'b1) begin nerr++;
      $display("FAIL %s_boot1 state=%0d flush=%0b want 0/1", tag, bus.state, bus.idex_flush); end
    tick();
    nvec++; if (bus.state !== 2'd0 || bus.idex_flush !== 1'b1 || bus.pc_enable !== 1'b1) begin nerr++;
      $display("FAIL %s_boot2 state=%0d flush=%0b pce=%0b want 0/1/1", tag, bus.state, bus.idex_flush, bus.pc_enable); end
    tick();
    nvec++; if (bus.state !== 2'd1 || bus.idex_flush !== 1'b0 || bus.pc_enable !== 1'b1 || bus.ifid_enable !== 1'b1) begin nerr++;
      $display("FAIL %s_run state=%0d flush=%0b pce=%0b ifid=%0b want 1/0/1/1", tag, bus.state, bus.idex_flush, bus.pc_enable, bus.ifid_enable); end
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 rst = 1'b1;
    #2;
    nvec++; if (bus.state !== 2'd0 || bus.stall_count !== 16'd0) begin nerr++;
      $display("FAIL reset_state state=%0d cnt=%0d want 0/0", bus.state, bus.stall_count); end
    nvec++; if (bus.idex_flush !== 1'b1 || bus.pc_sel !== 1'b0 || bus.pc_target !== 10'd0) begin nerr++;
      $display("FAIL reset_outputs flush=%0b sel=%0b tgt=%h want 1/0/000", bus.idex_flush, bus.pc_sel, bus.pc_target); end
    tick();
    rst = 1'b0;
    check_boot("reset");
  endtask

  task automatic test_jump();
    bus.jmp_enable_ex = 1'b1; bus.jmp_dir_ex = 10'h155;
    #1;
    nvec++; if (bus.pc_sel !== 1'b1 || bus.pc_target !== 10'h155 || bus.idex_flush !== 1'b1 || bus.pc_enable !== 1'b1) begin nerr++;
      $display("FAIL jump_redirect sel=%0b tgt=%h flush=%0b pce=%0b want 1/155/1/1", bus.pc_sel, bus.pc_target, bus.idex_flush, bus.pc_enable); end
    tick();
    // Jump left asserted and a hazard raised: FLUSH must ignore both.
    bus.read_a_id = 1'b1; bus.sel_a_ex = 2'b01;
    #1;
    nvec++; if (bus.state !== 2'd2 || bus.idex_flush !== 1'b1 || bus.pc_sel !== 1'b0 || bus.pc_target !== 10'd0 || bus.pc_enable !== 1'b1) begin nerr++;
      $display("FAIL jump_flush1 state=%0d flush=%0b sel=%0b tgt=%h pce=%0b want 2/1/0/000/1", bus.state, bus.idex_flush, bus.pc_sel, bus.pc_target, bus.pc_enable); end
    tick();
    clear_inputs();
    #1;
    nvec++; if (bus.state !== 2'd2 || bus.idex_flush !== 1'b1) begin nerr++;
      $display("FAIL jump_flush2 state=%0d flush=%0b want 2/1", bus.state, bus.idex_flush); end
    tick();
    nvec++; if (bus.state !== 2'd1 || bus.idex_flush !== 1'b0 || bus.stall_count !== exp_stall) begin nerr++;
      $display("FAIL jump_back_run state=%0d flush=%0b cnt=%0d want 1/0/%0d", bus.state, bus.idex_flush, bus.stall_count, exp_stall); end
  endtask

  task automatic test_branch();
    // {pc, offset, expected target}
    logic [9:0] pcs  [4] = '{10'h3FF, 10'h000, 10'h00A, 10'h100};
    logic [5:0] offs [4] = '{6'h01,   6'h3F,   6'h20,   6'h1F};
    logic [9:0] exps [4] = '{10'h000, 10'h3FF, 10'h3EA, 10'h11F};
    for (int i = 0; i < 4; i++) begin
      bus.branch_enable_ex = 1'b1; bus.branch_cond = 1'b1;
      bus.pc_ex = pcs[i]; bus.branch_dir_ex = offs[i];
      #1;
      nvec++; if (bus.pc_sel !== 1'b1 || bus.pc_target !== exps[i] || bus.idex_flush !== 1'b1) begin nerr++;
        $display("FAIL branch_taken_%0d sel=%0b tgt=%h flush=%0b want 1/%h/1", i, bus.pc_sel, bus.pc_target, bus.idex_flush, exps[i]); end
      tick();
      flush_out();
    end
    bus.branch_enable_ex = 1'b1; bus.branch_cond = 1'b0;
    bus.pc_ex = 10'h3FF; bus.branch_dir_ex = 6'h01;
    #1;
    nvec++; if (bus.pc_sel !== 1'b0 || bus.idex_flush !== 1'b0 || bus.pc_target !== 10'd0) begin nerr++;
      $display("FAIL branch_not_taken sel=%0b flush=%0b tgt=%h want 0/0/000", bus.pc_sel, bus.idex_flush, bus.pc_target); end
    tick();
    nvec++; if (bus.state !== 2'd1) begin nerr++;
      $display("FAIL branch_not_taken_state got %0d want 1", bus.state); end
    // Jump wins over a taken branch.
    bus.branch_cond = 1'b1; bus.jmp_enable_ex = 1'b1; bus.jmp_dir_ex = 10'h2A5;
    #1;
    nvec++; if (bus.pc_sel !== 1'b1 || bus.pc_target !== 10'h2A5) begin nerr++;
      $display("FAIL jump_precedence sel=%0b tgt=%h want 1/2a5", bus.pc_sel, bus.pc_target); end
    tick();
    flush_out();
  endtask

  task automatic test_stall();
    bus.read_a_id = 1'b1; bus.sel_a_ex = 2'b01;
    #1;
    nvec++; if (bus.pc_enable !== 1'b0 || bus.ifid_enable !== 1'b0 || bus.idex_flush !== 1'b1 || bus.state !== 2'd1) begin nerr++;
      $display("FAIL stall_c1 pce=%0b ifid=%0b flush=%0b state=%0d want 0/0/1/1", bus.pc_enable, bus.ifid_enable, bus.idex_flush, bus.state); end
    tick();
    bus.sel_a_ex = 2'b00; bus.sel_a_me = 2'b01;
    #1;
    nvec++; if (bus.pc_enable !== 1'b0 || bus.state !== 2'd3) begin nerr++;
      $display("FAIL stall_c2 pce=%0b state=%0d want 0/3", bus.pc_enable, bus.state); end
    tick();
    bus.sel_a_me = 2'b00; bus.sel_a_wb = 2'b01;
    #1;
    nvec++; if (bus.pc_enable !== 1'b0 || bus.state !== 2'd3 || bus.stall_count !== 16'd2) begin nerr++;
      $display("FAIL stall_c3_wb pce=%0b state=%0d cnt=%0d want 0/3/2", bus.pc_enable, bus.state, bus.stall_count); end
    tick();
    bus.sel_a_wb = 2'b00;
    #1;
    nvec++; if (bus.pc_enable !== 1'b1 || bus.idex_flush !== 1'b0 || bus.stall_count !== 16'd3) begin nerr++;
      $display("FAIL stall_release pce=%0b flush=%0b cnt=%0d want 1/0/3", bus.pc_enable, bus.idex_flush, bus.stall_count); end
    tick();
    exp_stall = 16'd3;
    nvec++; if (bus.state !== 2'd1) begin nerr++;
      $display("FAIL stall_back_run state=%0d want 1", bus.state); end
    // Port B read against a WB write is a hazard.
    bus.read_a_id = 1'b0; bus.read_b_id = 1'b1; bus.sel_b_wb = 2'b10;
    #1;
    nvec++; if (bus.pc_enable !== 1'b0 || bus.ifid_enable !== 1'b0) begin nerr++;
      $display("FAIL hazard_b_wb pce=%0b ifid=%0b want 0/0", bus.pc_enable, bus.ifid_enable); end
    tick();
    exp_stall = exp_stall + 16'd1;
    // Writes on the other port, or without a read flag, are not hazards.
    bus.read_b_id = 1'b0; bus.sel_b_wb = 2'b00; bus.read_a_id = 1'b1;
    bus.sel_b_ex = 2'b11; bus.sel_b_me = 2'b01;
    #1;
    nvec++; if (bus.pc_enable !== 1'b1 || bus.idex_flush !== 1'b0) begin nerr++;
      $display("FAIL no_hazard_cross pce=%0b flush=%0b want 1/0", bus.pc_enable, bus.idex_flush); end
    tick();
    clear_inputs();
    nvec++; if (bus.state !== 2'd1 || bus.stall_count !== exp_stall) begin nerr++;
      $display("FAIL no_hazard_state state=%0d cnt=%0d want 1/%0d", bus.state, bus.stall_count, exp_stall); end
  endtask

  task automatic test_priority();
    bus.read_a_id = 1'b1; bus.sel_a_me = 2'b10;
    bus.branch_enable_ex = 1'b1; bus.branch_cond = 1'b1;
    bus.pc_ex = 10'h010; bus.branch_dir_ex = 6'h05;
    #1;
    nvec++; if (bus.pc_sel !== 1'b1 || bus.pc_enable !== 1'b1 || bus.pc_target !== 10'h015 || bus.idex_flush !== 1'b1) begin nerr++;
      $display("FAIL prio_redirect sel=%0b pce=%0b tgt=%h flush=%0b want 1/1/015/1", bus.pc_sel, bus.pc_enable, bus.pc_target, bus.idex_flush); end
    tick();
    nvec++; if (bus.state !== 2'd2 || bus.stall_count !== exp_stall) begin nerr++;
      $display("FAIL prio_no_count state=%0d cnt=%0d want 2/%0d", bus.state, bus.stall_count, exp_stall); end
    flush_out();
  endtask

  task automatic test_saturate();
    int n;
    n = 65535 - int'(exp_stall) + 4;
    bus.read_b_id = 1'b1; bus.sel_b_ex = 2'b01;
    for (int i = 0; i < n; i++) begin
      tick();
      if (exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    end
    #1;
    nvec++; if (bus.stall_count !== 16'hFFFF || bus.state !== 2'd3 || bus.pc_enable !== 1'b0) begin nerr++;
      $display("FAIL sat_hold cnt=%h state=%0d pce=%0b want ffff/3/0", bus.stall_count, bus.state, bus.pc_enable); end
    tick();
    nvec++; if (bus.stall_count !== 16'hFFFF) begin nerr++;
      $display("FAIL sat_stays cnt=%h want ffff", bus.stall_count); end
    clear_inputs();
    tick();
    nvec++; if (bus.state !== 2'd1 || bus.stall_count !== 16'hFFFF) begin nerr++;
      $display("FAIL sat_back_run state=%0d cnt=%h want 1/ffff", bus.state, bus.stall_count); end
  endtask

  task automatic test_reset_mid_flush();
    bus.jmp_enable_ex = 1'b1; bus.jmp_dir_ex = 10'h0F0;
    tick();
    clear_inputs();
    tick();
    nvec++; if (bus.state !== 2'd2) begin nerr++;
      $display("FAIL midflush_state got %0d want 2", bus.state); end
    #2 rst = 1'b1;
    #1;
    nvec++; if (bus.state !== 2'd0 || bus.stall_count !== 16'd0 || bus.idex_flush !== 1'b1 || bus.pc_sel !== 1'b0) begin nerr++;
      $display("FAIL midflush_async state=%0d cnt=%h flush=%0b sel=%0b want 0/0000/1/0", bus.state, bus.stall_count, bus.idex_flush, bus.pc_sel); end
    tick();
    rst = 1'b0;
    check_boot("rerst");
  endtask

  initial begin
    test_reset();
    test_jump();
    test_branch();
    test_stall();
    test_priority();
    test_saturate();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter BOOT_CYCLES, default 2, SHALL set the number of bubble cycles issued after reset while the synchronous ROM fills IF.
REQ-002 Parameter FLUSH_CYCLES, default 2, SHALL set the number of bubble cycles issued after a taken redirect.
REQ-003 Clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 iPCEX  in  10  SHALL be the PC of the instruction currently in EX.
REQ-006 iJmpEnableEX  in  1  SHALL flag an unconditional jump in EX; iJmpDirEX  in  10  is its absolute target.
REQ-007 iBranchEnableEX  in  1  SHALL flag a conditional branch in EX; iBranchDirEX  in  6  is its signed offset; iBranchCond  in  1  is its evaluated condition.
REQ-008 iReadA_ID, iReadB_ID  in  1 each  SHALL flag that the ID instruction reads register A or B.
REQ-009 iSelAEX, iSelAME, iSelAWB, iSelBEX, iSelBME, iSelBWB  in  2 each  SHALL be the in-flight register write selects; 2'b00 means no write.
REQ-010 oPCSel  out  1  SHALL select oPCTarget (1) over PC+1 (0) at the PC input mux.
REQ-011 oPCTarget  out  10  SHALL be the redirect address.
REQ-012 oPCEnable, oIFIDEnable  out  1 each  SHALL enable the PC register and the IF/ID capture.
REQ-013 oIDEXFlush  out  1  SHALL force all ID/EX control registers to zero (bubble) at the next edge.
REQ-014 oState  out  2  SHALL report the FSM state: BOOT=0, RUN=1, FLUSH=2, STALL=3.
REQ-015 oStallCount  out  16  SHALL count STALL-producing cycles, saturating at 16'hFFFF.

Function
REQ-016 Redirect SHALL be asserted when iJmpEnableEX=1, or when iBranchEnableEX=1 and iBranchCond=1; jump takes precedence if both are set.
REQ-017 Jump target SHALL be iJmpDirEX; branch target SHALL be iPCEX + sign-extended iBranchDirEX, modulo 1024 (wraps 1023+1 to 0 and 0-1 to 1023).
REQ-018 Hazard SHALL be asserted when (iReadA_ID and any of iSelAEX/ME/WB != 0) or (iReadB_ID and any of iSelBEX/ME/WB != 0).
REQ-019 All outputs except oState and oStallCount SHALL be combinational functions of the current state, counter and inputs; the default (normal) output values SHALL be oPCSel=0, oPCEnable=1, oIFIDEnable=1, oIDEXFlush=0.
REQ-020 In BOOT, the block SHALL drive oIDEXFlush=1 and oPCSel=0 with the PC enabled, decrement the counter each cycle, and go to RUN after the cycle in which the counter is 0 (BOOT_CYCLES cycles in total).
REQ-021 In RUN or STALL, if redirect is asserted, the block SHALL drive oPCSel=1, oPCTarget=target, oPCEnable=1 and oIDEXFlush=1, load the counter with FLUSH_CYCLES-1, and go to FLUSH.
REQ-022 In RUN or STALL, if there is a hazard and no redirect, the block SHALL drive oPCEnable=0, oIFIDEnable=0 and oIDEXFlush=1, increment oStallCount, and enter or stay in STALL.
REQ-023 In RUN or STALL, with neither a redirect nor a hazard, the block SHALL use normal outputs and go to (or stay in) RUN.
REQ-024 Redirect SHALL have priority over a hazard in the same cycle; the stalled ID instruction is squashed by that cycle's flush.
REQ-025 In FLUSH, the block SHALL drive oIDEXFlush=1 with the PC enabled, ignore the redirect and hazard inputs, decrement the counter, and go to RUN after the counter-0 cycle.
REQ-026 When no redirect is active, oPCTarget SHALL hold 10'd0.
REQ-027 Writes in the WB stage SHALL count as a hazard, because the register files update at the end of the WB cycle.

Reset
REQ-028 Reset=1 SHALL immediately, without waiting for a clock edge, set state=BOOT, counter=BOOT_CYCLES-1 and oStallCount=0, with outputs at their BOOT values (oIDEXFlush=1, oPCSel=0, oPCTarget=0).
REQ-029 Reset asserted mid-FLUSH or mid-STALL SHALL abandon that operation; on release the block SHALL run a full BOOT sequence.

Verification
REQ-030 Release reset with all inputs 0 -> oState 0 for 2 cycles with oIDEXFlush=1, then oState=1 with oIDEXFlush=0.
REQ-031 In RUN, iJmpEnableEX=1 and iJmpDirEX=10'h155 for one cycle -> that cycle oPCSel=1 and oPCTarget=10'h155, then oIDEXFlush=1 for 3 cycles in total, then RUN.
REQ-032 Branch with iPCEX=10'h3FF, iBranchDirEX=6'h01, iBranchCond=1 -> oPCTarget=0; the same case with iBranchCond=0 -> oPCSel=0 and no flush.
REQ-033 iReadA_ID=1 with iSelAEX=2'b01, which moves to ME and then WB over the next 2 cycles -> 3 stall cycles (oPCEnable=0, oState=3), oStallCount=3, then RUN.
REQ-034 A hazard and a taken branch in the same cycle -> redirect outputs with oPCEnable=1 and no oStallCount increment; oStallCount held at 16'hFFFF under a hazard -> stays at 16'hFFFF.
REQ-035 Assert Reset in the second FLUSH cycle -> oState=0 and oStallCount=0 with no clock edge, then a full BOOT sequence after release.
